// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer and the
// datapath muxes it steers.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } iclass_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] PC_PLUS4 = 2'd0, PC_IMM  = 2'd1, PC_ALU   = 2'd2;
  localparam logic [1:0] A_RS1    = 2'd0, A_PC    = 2'd1, A_ZERO   = 2'd2;
  localparam logic [1:0] B_RS2    = 2'd0, B_IMM   = 2'd1;
  localparam logic [1:0] OP_ADD   = 2'd0, OP_CMP  = 2'd1, OP_FUNC  = 2'd2;
  localparam logic [1:0] WB_ALU   = 2'd0, WB_MEM  = 2'd1, WB_PC4   = 2'd2;
  localparam logic [1:0] TC_NONE  = 2'd0, TC_ILLEGAL = 2'd1, TC_TIMEOUT = 2'd2;

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Unified memory port handshake between the sequencer and the memory.
interface cpu_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, mem_we, mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr_sel, output mem_ready);
endinterface

// File: rtl/ctrl_decode.sv
// Opcode classifier: maps IR[6:0] to an instruction class plus illegal flag.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    cls,
  output logic       illegal
);
  // Pure lookup; unknown opcodes flag illegal and report class R.
  always_comb begin
    cls     = C_R;
    illegal = 1'b0;
    case (opcode)
      OPC_R:      cls = C_R;
      OPC_I:      cls = C_I;
      OPC_LOAD:   cls = C_LOAD;
      OPC_STORE:  cls = C_STORE;
      OPC_BRANCH: cls = C_BRANCH;
      OPC_JAL:    cls = C_JAL;
      OPC_JALR:   cls = C_JALR;
      OPC_LUI:    cls = C_LUI;
      OPC_AUIPC:  cls = C_AUIPC;
      default:    illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/cpu_control_fsm.sv
// RV32I multi-cycle control sequencer with retired-instruction counter.
// Optional memory-wait watchdog enabled by defining CTRL_TIMEOUT_EN.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [6:0]                opcode,
  input  logic                      branch_taken,
  cpu_control_fsm_if.master         mem,
  output logic                      ir_we,
  output logic                      pc_we,
  output logic                      alu_out_we,
  output logic                      rf_we,
  output logic [1:0]                pc_sel,
  output logic [1:0]                alu_src_a,
  output logic [1:0]                alu_src_b,
  output logic [1:0]                alu_op,
  output logic [1:0]                wb_sel,
  output logic                      halted,
  output logic [1:0]                trap_cause,
  output logic [31:0]               instret
);

  state_t  state, nxt;
  iclass_t cls_q, dec_cls;
  logic    dec_ill;
  logic [1:0] trap_q;
  logic    retire;
  logic    tmo;

  ctrl_decode u_dec (.opcode(opcode), .cls(dec_cls), .illegal(dec_ill));

`ifdef CTRL_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;
  logic in_mem;
  assign in_mem = (state == S_FETCH) || (state == S_MEM);

  // Count stalled memory cycles; a completed or absent request clears it,
  // so every new request starts from zero.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                      wait_cnt <= '0;
    else if (in_mem && !mem.mem_ready) wait_cnt <= wait_cnt + 1'b1;
    else                             wait_cnt <= '0;

  assign tmo = in_mem && !mem.mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  // State, latched class, sticky trap cause and retire counter.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= S_IDLE;
      cls_q   <= C_R;
      trap_q  <= TC_NONE;
      instret <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) cls_q <= dec_cls;
      if (nxt == S_TRAP && state != S_TRAP)
        trap_q <= (state == S_DECODE) ? TC_ILLEGAL : TC_TIMEOUT;
      if (retire) instret <= instret + 32'd1;
    end

  // Next state and per-state datapath strobes/selects.
  always_comb begin
    nxt              = state;
    retire           = 1'b0;
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_we            = 1'b0;
    pc_we            = 1'b0;
    alu_out_we       = 1'b0;
    rf_we            = 1'b0;
    pc_sel           = PC_PLUS4;
    alu_src_a        = A_RS1;
    alu_src_b        = B_RS2;
    alu_op           = OP_ADD;
    wb_sel           = WB_ALU;
    case (state)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_we = 1'b1;
          nxt   = S_DECODE;
        end else if (tmo) nxt = S_TRAP;
      end
      S_DECODE: nxt = dec_ill ? S_TRAP : S_EXECUTE;
      S_EXECUTE: begin
        alu_out_we = 1'b1;
        nxt        = S_WB;
        case (cls_q)
          C_R:     alu_op = OP_FUNC;
          C_I:     begin alu_src_b = B_IMM; alu_op = OP_FUNC; end
          C_LOAD, C_STORE: begin alu_src_b = B_IMM; nxt = S_MEM; end
          C_LUI:   begin alu_src_a = A_ZERO; alu_src_b = B_IMM; end
          C_AUIPC, C_JAL: begin alu_src_a = A_PC; alu_src_b = B_IMM; end
          C_JALR:  alu_src_b = B_IMM;
          C_BRANCH: begin
            alu_op = OP_CMP;
            pc_we  = 1'b1;
            pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
            retire = 1'b1;
            nxt    = S_FETCH;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem.mem_req      = 1'b1;
        mem.mem_addr_sel = 1'b1;
        mem.mem_we       = (cls_q == C_STORE);
        if (mem.mem_ready) begin
          if (cls_q == C_STORE) begin
            pc_we  = 1'b1;
            retire = 1'b1;
            nxt    = S_FETCH;
          end else nxt = S_WB;
        end else if (tmo) nxt = S_TRAP;
      end
      S_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        nxt    = S_FETCH;
        if (cls_q == C_LOAD) wb_sel = WB_MEM;
        if (cls_q == C_JAL || cls_q == C_JALR) begin
          wb_sel = WB_PC4;
          pc_sel = PC_ALU;
        end
      end
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_IDLE;
    endcase
  end

  assign halted     = (state == S_TRAP);
  assign trap_cause = trap_q;

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle control sequencer for the RV32I core. Classifies the latched instruction opcode and walks it through fetch, decode, execute, memory and writeback states. Each state drives the datapath strobes and mux selects: PC, IR, ALU-out register, register file, ALU operand/op selects and the memory request handshake. The block sits between the instruction register and the shared datapath (ALU, register file, immediate generator, unified memory port) and also counts retired instructions.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum memory wait cycles; used only with `CTRL_TIMEOUT_EN`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `opcode`  in  7  IR[6:0]; stable from the cycle after `ir_we`.
- `branch_taken`  in  1  comparator result for the current branch; valid in EXECUTE.
- `mem_ready`  in  1  memory completion; may assert in the first cycle of `mem_req`.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  store qualifier for `mem_req`.
- `mem_addr_sel`  out  1  memory address source: 0=PC, 1=ALU-out register.
- `ir_we`, `pc_we`, `alu_out_we`, `rf_we`  out  1 each  register write strobes.
- `pc_sel`  out  2  next-PC source: 0=PC+4, 1=PC+imm, 2=ALU-out.
- `alu_src_a`  out  2  ALU operand A: 0=rs1, 1=PC, 2=zero.
- `alu_src_b`  out  2  ALU operand B: 0=rs2, 1=imm.
- `alu_op`  out  2  ALU function: 0=add, 1=compare, 2=funct3/funct7 decode.
- `wb_sel`  out  2  writeback source: 0=ALU-out, 1=memory data, 2=PC+4.
- `halted`  out  1  core is in TRAP.
- `trap_cause`  out  2  trap reason: 0=none, 1=illegal opcode, 2=memory timeout.
- `instret`  out  32  retired-instruction counter.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
- Classes latched in DECODE: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. Any other opcode is illegal.
- Outputs are decoded from the state and the latched class. Every strobe and select not listed for a state is 0.
- IDLE: no outputs active; next state is FETCH unconditionally.
- FETCH: `mem_req`=1, `mem_addr_sel`=0. Stay in FETCH until `mem_ready`. In the `mem_ready` cycle, `ir_we`=1 and the next state is DECODE.
- DECODE: latch the class. Illegal opcode goes to TRAP with `trap_cause`=1; any other opcode goes to EXECUTE.
- EXECUTE, `alu_out_we`=1 in every case:
  - R: a=0, b=0, op=2, then WB.
  - I-ALU: a=0, b=1, op=2, then WB.
  - LOAD/STORE: a=0, b=1, op=0, then MEM.
  - LUI: a=2, b=1, then WB.
  - AUIPC: a=1, b=1, then WB.
  - JAL: a=1, b=1, then WB.
  - JALR: a=0, b=1, then WB.
  - BRANCH: op=1, `pc_we`=1, `pc_sel`=1 if `branch_taken` else 0, then FETCH; the instruction retires here.
- MEM: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=1 for STORE. Hold all outputs until `mem_ready`.
  - LOAD then goes to WB.
  - STORE asserts `pc_we`=1, `pc_sel`=0 in the `mem_ready` cycle, retires, and goes to FETCH.
- WB: `rf_we`=1, `pc_we`=1, then FETCH; the instruction retires here.
  - `wb_sel`: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - `pc_sel`: 2 for JAL/JALR, 0 otherwise.
- TRAP: `halted`=1 and `trap_cause` is held. No strobes. The state is left only by reset.
- `instret` increments by 1 in each retire cycle and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset values: state IDLE; every output 0; `instret`=0; `trap_cause`=0.
- Reset asserted mid-operation returns to IDLE immediately. An outstanding memory request is dropped (`mem_req` goes to 0 asynchronously).
- Zero-wait latencies, FETCH through retire: BRANCH 3 cycles; R/I/LUI/AUIPC/JAL/JALR 4; STORE 4; LOAD 5.
- Each memory wait cycle adds one cycle.
- Handshake: once `mem_req` rises, `mem_req`, `mem_we` and `mem_addr_sel` stay constant until the cycle in which `mem_ready`=1, inclusive. A `mem_ready` seen while `mem_req`=0 is ignored.
- The `halted` rise is visible in the cycle after DECODE.

## Configuration
- `CTRL_TIMEOUT_EN` defined:
  - An 8+ bit wait counter clears whenever a new `mem_req` begins and counts each FETCH/MEM cycle in which `mem_ready`=0.
  - When the count reaches `TIMEOUT_CYCLES`, the next state is TRAP with `trap_cause`=2, and `mem_req` drops on entry to TRAP.
- `CTRL_TIMEOUT_EN` undefined: no counter, and the block waits forever. `trap_cause`=2 is unreachable.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state enum;
  - the instruction-class enum;
  - the opcode constants;
  - the `pc_sel`/`alu_src_a`/`alu_src_b`/`alu_op`/`wb_sel` encodings;
  - the `trap_cause` encodings.
  These constants are shared with the datapath muxes.
- One combinational sub-module, `ctrl_decode`, maps opcode to class plus an illegal flag. The FSM, `instret` and the timeout counter live in `cpu_control_fsm`.

## Test plan
- Reset release, zero-wait memory, ADDI (0010011): IDLE, FETCH, DECODE, EXECUTE (b=1, op=2), WB (`rf_we`=1, `pc_sel`=0), FETCH. `instret`=1.
- LW with `mem_ready` delayed 3 cycles in MEM: `mem_req`, `mem_addr_sel`=1 and `mem_we`=0 stay stable for 4 cycles, then WB with `wb_sel`=1. Total 8 cycles.
- BEQ with `branch_taken`=1, then with 0: `pc_sel`=1 and then 0 in EXECUTE, each retiring in 3 cycles. `instret` advances by 2.
- Opcode 0000000: TRAP after DECODE, `halted`=1, `trap_cause`=1. FSM stays halted for 20 cycles; `rst_n` low returns to IDLE with `halted`=0.
- `CTRL_TIMEOUT_EN` with `TIMEOUT_CYCLES`=4 and `mem_ready` held 0 in FETCH: TRAP with `trap_cause`=2 after 4 wait cycles; `mem_req`=0 thereafter.
- `instret` preloaded to 0xFFFFFFFF via force, then one SW: wraps to 0. Asserting `rst_n` low mid-MEM drives `mem_req` low in the same cycle.
